// File: rtl/shmem_responder.sv
// rtl/shmem_responder.sv - shared unit-addressed memory served to NPORT processor ports under round-robin ownership
//
// Purpose: a DEPTH-unit memory (UNIT_SIZE bits per unit) shared by NPORT requesters.
// One port at a time owns the memory; ownership is granted round-robin from IDLE
// and held for as long as the owner keeps a read or write request asserted.
// Reads return WIDTH consecutive units (wrapping modulo DEPTH) combinationally;
// writes store up to WIDTH units on the clock edge.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rstn      asynchronous active-low reset; clears FSM, owner, priority and memory
//   i_req_rd    per-port read request
//   i_req_wr    per-port write request
//   i_addr      per-port starting unit address, port p at [p*ADDR_W +: ADDR_W]
//   i_wr_data   per-port write beat, unit k at [k*UNIT_SIZE +: UNIT_SIZE]
//   i_wr_size   per-port number of units to write (clamped to WIDTH)
//   i_wr_en     per-port write strobe
//   o_grant_rd  read grant, one-hot or zero
//   o_grant_wr  write grant, one-hot or zero
//   o_rd_data   read beat for the owning port, zero without a read grant
//   o_owner     registered owner index
//   o_busy      ownership active
module shmem_responder #(
    parameter int NPORT     = 4,
    parameter int UNIT_SIZE = 16,
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 256,
    localparam int BUS_W    = WIDTH * UNIT_SIZE,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int OWN_W    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NPORT-1:0]          i_req_rd,
    input  logic [NPORT-1:0]          i_req_wr,
    input  logic [NPORT*ADDR_W-1:0]   i_addr,
    input  logic [NPORT*BUS_W-1:0]    i_wr_data,
    input  logic [NPORT*3-1:0]        i_wr_size,
    input  logic [NPORT-1:0]          i_wr_en,
    output logic [NPORT-1:0]          o_grant_rd,
    output logic [NPORT-1:0]          o_grant_wr,
    output logic [BUS_W-1:0]          o_rd_data,
    output logic [OWN_W-1:0]          o_owner,
    output logic                      o_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t               state_q;
    logic [OWN_W-1:0]     owner_q;
    logic [OWN_W-1:0]     last_q;

    logic [UNIT_SIZE-1:0] mem [DEPTH];

    logic [NPORT-1:0]     req_any;
    logic [OWN_W-1:0]     rr_sel;
    logic                 rr_found;

    logic                 own_rd;
    logic                 own_wr;
    logic                 own_en;
    logic [ADDR_W-1:0]    own_addr;
    logic [BUS_W-1:0]     own_wdata;
    logic [2:0]           own_size;

    logic                 owned;
    logic                 wr_fire;
    logic [ADDR_W-1:0]    unit_addr [WIDTH];

    // Unit address base+k folded back into 0..DEPTH-1. k < WIDTH <= DEPTH, so one
    // conditional subtract is enough and DEPTH need not be a power of two.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return ADDR_W'(s);
    endfunction

    assign req_any = i_req_rd | i_req_wr;
    assign owned   = (state_q == ST_OWNED);

    // Round-robin pick: scan ports last+1, last+2, ... (mod NPORT); first requester wins.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= NPORT; i++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!rr_found && (p == ((int'(last_q) + i) % NPORT)) && req_any[p]) begin
                    rr_sel   = OWN_W'(p);
                    rr_found = 1'b1;
                end
            end
        end
    end

    // Mux out the owning port's request signals.
    always_comb begin
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        own_en    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_size  = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (int'(owner_q) == p) begin
                own_rd    = i_req_rd[p];
                own_wr    = i_req_wr[p];
                own_en    = i_wr_en[p];
                own_addr  = i_addr[p*ADDR_W +: ADDR_W];
                own_wdata = i_wr_data[p*BUS_W +: BUS_W];
                own_size  = i_wr_size[p*3 +: 3];
            end
        end
    end

    // Grants follow the owner's live requests; non-owners never see a grant.
    always_comb begin
        o_grant_rd = '0;
        o_grant_wr = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (owned && (int'(owner_q) == p)) begin
                o_grant_rd[p] = i_req_rd[p];
                o_grant_wr[p] = i_req_wr[p];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            unit_addr[k] = wrap_addr(own_addr, k);
        end
    end

    // Read path taps the array before this edge's write lands, so a same-cycle
    // read of a unit being written returns the old contents.
    always_comb begin
        o_rd_data = '0;
        if (owned && own_rd) begin
            for (int k = 0; k < WIDTH; k++) begin
                o_rd_data[k*UNIT_SIZE +: UNIT_SIZE] = mem[unit_addr[k]];
            end
        end
    end

    assign wr_fire = owned && own_wr && own_en;

    // Ownership FSM. Dropping both requests costs one cycle back to IDLE, and
    // IDLE then arbitrates, which guarantees a gap cycle between owners.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(NPORT - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_any) begin
                        owner_q <= rr_sel;
                        state_q <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!(own_rd || own_wr)) begin
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory: cleared by reset, which also swallows any write in flight.
    // Only units 0..min(size,WIDTH)-1 of the beat are stored.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int u = 0; u < DEPTH; u++) begin
                mem[u] <= '0;
            end
        end else if (wr_fire) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (k < int'(own_size)) begin
                    mem[unit_addr[k]] <= own_wdata[k*UNIT_SIZE +: UNIT_SIZE];
                end
            end
        end
    end

    assign o_owner = owner_q;
    assign o_busy  = owned;

endmodule

// File: tb/tb_shmem_responder.sv
// tb/tb_shmem_responder.sv - directed self-checking bench for shmem_responder
module tb_shmem_responder;

    logic         clk;
    logic         rstn;
    logic [3:0]   req_rd;
    logic [3:0]   req_wr;
    logic [31:0]  addr;
    logic [255:0] wr_data;
    logic [11:0]  wr_size;
    logic [3:0]   wr_en;
    logic [3:0]   grant_rd;
    logic [3:0]   grant_wr;
    logic [63:0]  rd_data;
    logic [1:0]   owner;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    shmem_responder #(
        .NPORT(4), .UNIT_SIZE(16), .WIDTH(4), .DEPTH(256)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_rd   (req_rd),
        .i_req_wr   (req_wr),
        .i_addr     (addr),
        .i_wr_data  (wr_data),
        .i_wr_size  (wr_size),
        .i_wr_en    (wr_en),
        .o_grant_rd (grant_rd),
        .o_grant_wr (grant_wr),
        .o_rd_data  (rd_data),
        .o_owner    (owner),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] pk(input logic [15:0] u0, input logic [15:0] u1,
                                       input logic [15:0] u2, input logic [15:0] u3);
        return {u3, u2, u1, u0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        req_rd  = '0;
        req_wr  = '0;
        addr    = '0;
        wr_data = '0;
        wr_size = '0;
        wr_en   = '0;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [7:0] a,
                            input logic [63:0] d, input logic [2:0] sz, input logic e);
        req_rd[p]           = rd;
        req_wr[p]           = wr;
        addr[p*8 +: 8]      = a;
        wr_data[p*64 +: 64] = d;
        wr_size[p*3 +: 3]   = sz;
        wr_en[p]            = e;
    endtask

    initial begin
        logic [3:0] exp_g;

        rstn = 1'b0;
        clear_all();
        repeat (3) tick();
        chk("rst_grant_rd", 64'(grant_rd), 64'h0);
        chk("rst_grant_wr", 64'(grant_wr), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_owner", 64'(owner), 64'h0);
        rstn = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'h0);

        // Three ports request together, each holds 3 granted cycles then drops.
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 8'd0, 64'h0, 3'd0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (c == 4)  req_rd[0] = 1'b0;
            if (c == 9)  req_rd[1] = 1'b0;
            if (c == 14) req_rd[2] = 1'b0;
            settle();
            if (c >= 1 && c <= 3)        exp_g = 4'b0001;
            else if (c >= 6 && c <= 8)   exp_g = 4'b0010;
            else if (c >= 11 && c <= 13) exp_g = 4'b0100;
            else                         exp_g = 4'b0000;
            chk($sformatf("rr_grant_c%0d", c), 64'(grant_rd), 64'(exp_g));
            tick();
        end

        // Port 0 writes 1,2,3,4 at 10 then reads it back.
        clear_all();
        set_port(0, 1'b0, 1'b1, 8'd10, pk(1, 2, 3, 4), 3'd4, 1'b1);
        settle();
        chk("wr0_pre_grant", 64'(grant_wr), 64'h0);
        tick();
        chk("wr0_grant", 64'(grant_wr), 64'h1);
        chk("wr0_owner", 64'(owner), 64'h0);
        chk("wr0_busy", 64'(busy), 64'h1);
        chk("wr0_no_rd_data", rd_data, 64'h0);
        tick();
        set_port(0, 1'b1, 1'b0, 8'd10, 64'h0, 3'd0, 1'b0);
        settle();
        chk("rd0_grant", 64'(grant_rd), 64'h1);
        chk("rd0_grant_wr", 64'(grant_wr), 64'h0);
        chk("rd0_data", rd_data, pk(1, 2, 3, 4));
        clear_all();
        settle();
        chk("rel0_grant", 64'(grant_rd), 64'h0);
        chk("rel0_data", rd_data, 64'h0);
        chk("rel0_busy", 64'(busy), 64'h1);
        tick();
        chk("rel0_idle", 64'(busy), 64'h0);

        // Port 1 wrapping write at 254.
        set_port(1, 1'b0, 1'b1, 8'd254, pk(5, 6, 7, 8), 3'd4, 1'b1);
        tick();
        chk("wrap_owner", 64'(owner), 64'h1);
        chk("wrap_grant", 64'(grant_wr), 64'h2);
        tick();
        set_port(1, 1'b1, 1'b0, 8'd254, 64'h0, 3'd0, 1'b0);
        settle();
        chk("wrap_rd254", rd_data, pk(5, 6, 7, 8));
        addr[15:8] = 8'd0;
        settle();
        chk("wrap_rd0", rd_data, pk(7, 8, 0, 0));
        addr[15:8] = 8'd255;
        settle();
        chk("wrap_rd255", rd_data, pk(6, 7, 8, 0));
        clear_all();
        tick();

        // Port 2 reads 2 cycles, then writes 1 cycle; port 3 waits with wr_en high.
        set_port(2, 1'b1, 1'b0, 8'd20, 64'h0, 3'd0, 1'b0);
        set_port(3, 1'b0, 1'b1, 8'd40, pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 3'd4, 1'b1);
        settle();
        chk("hold_pre_wr", 64'(grant_wr), 64'h0);
        tick();
        chk("hold_c1_owner", 64'(owner), 64'h2);
        chk("hold_c1_rd", 64'(grant_rd), 64'h4);
        chk("hold_c1_wr", 64'(grant_wr), 64'h0);
        tick();
        chk("hold_c2_rd", 64'(grant_rd), 64'h4);
        tick();
        set_port(2, 1'b0, 1'b1, 8'd20, pk(9, 9, 9, 9), 3'd4, 1'b1);
        settle();
        chk("hold_c3_wr", 64'(grant_wr), 64'h4);
        chk("hold_c3_rd", 64'(grant_rd), 64'h0);
        chk("hold_c3_owner", 64'(owner), 64'h2);
        tick();
        set_port(2, 1'b0, 1'b0, 8'd20, 64'h0, 3'd0, 1'b0);
        settle();
        chk("hold_c4_wr", 64'(grant_wr), 64'h0);
        chk("hold_c4_busy", 64'(busy), 64'h1);
        tick();
        chk("hold_c5_busy", 64'(busy), 64'h0);
        chk("hold_c5_wr", 64'(grant_wr), 64'h0);
        tick();
        chk("hold_c6_owner", 64'(owner), 64'h3);
        chk("hold_c6_wr", 64'(grant_wr), 64'h8);
        set_port(3, 1'b1, 1'b0, 8'd40, 64'h0, 3'd0, 1'b0);
        settle();
        chk("p3_rd_grant", 64'(grant_rd), 64'h8);
        chk("p3_nonowner_wr_ignored", rd_data, 64'h0);
        addr[31:24] = 8'd20;
        settle();
        chk("p3_rd20", rd_data, pk(9, 9, 9, 9));
        clear_all();
        tick();

        // Port 0: partial, simultaneous, zero-size and oversize writes at 20.
        set_port(0, 1'b0, 1'b1, 8'd20, pk(1, 2, 3, 4), 3'd2, 1'b1);
        tick();
        tick();
        set_port(0, 1'b1, 1'b0, 8'd20, 64'h0, 3'd0, 1'b0);
        settle();
        chk("size2", rd_data, pk(1, 2, 9, 9));
        set_port(0, 1'b1, 1'b1, 8'd20, pk(10, 11, 12, 13), 3'd4, 1'b1);
        settle();
        chk("both_grant_rd", 64'(grant_rd), 64'h1);
        chk("both_grant_wr", 64'(grant_wr), 64'h1);
        chk("both_old_data", rd_data, pk(1, 2, 9, 9));
        tick();
        set_port(0, 1'b1, 1'b1, 8'd20, pk(7, 7, 7, 7), 3'd0, 1'b1);
        settle();
        chk("both_new_data", rd_data, pk(10, 11, 12, 13));
        tick();
        chk("size0_nothing", rd_data, pk(10, 11, 12, 13));
        set_port(0, 1'b1, 1'b1, 8'd20, pk(5, 6, 7, 8), 3'd7, 1'b1);
        tick();
        chk("size7_clamped", rd_data, pk(5, 6, 7, 8));
        set_port(0, 1'b1, 1'b0, 8'd24, 64'h0, 3'd0, 1'b0);
        settle();
        chk("size7_no_spill", rd_data, 64'h0);
        clear_all();
        tick();

        // Reset pulsed while port 0 owns with a write pending.
        set_port(0, 1'b0, 1'b1, 8'd100, pk(16'h55, 0, 0, 0), 3'd1, 1'b1);
        tick();
        chk("mid_grant_wr", 64'(grant_wr), 64'h1);
        rstn = 1'b0;
        settle();
        chk("mid_rst_grant_wr", 64'(grant_wr), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_owner", 64'(owner), 64'h0);
        tick();
        clear_all();
        rstn = 1'b1;
        set_port(0, 1'b1, 1'b0, 8'd100, 64'h0, 3'd0, 1'b0);
        tick();
        chk("post_rst_grant", 64'(grant_rd), 64'h1);
        chk("post_rst_unit100", rd_data, 64'h0);
        addr[7:0] = 8'd10;
        settle();
        chk("post_rst_unit10", rd_data, 64'h0);
        clear_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
